// File: rtl/matrix_pkg.sv
// Shared sizing and FSM encoding for the 3x3 inverse-matrix result path.
// The state encoding is a plain 1-bit constant pair, so older tools can consume it.
package matrix_pkg;

    localparam int wordLength = 16;
    localparam int NELEM      = 9;
    localparam int IDX_W      = 4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

endpackage

// File: rtl/rise_detect.sv
// Single-cycle rising-edge pulse on d. The history flop clears on reset, so a
// level that is already high at the first clock after release counts as an edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic r_d_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_q <= 1'b0;
        end else begin
            r_d_q <= d;
        end
    end

    assign pulse = d & ~r_d_q;

endmodule

// File: rtl/inv_result_streamer.sv
// Captures one 3x3 inverse from the CORDIC inversion pipeline and streams it
// row-major as nine valid/ready beats, flagging results that arrive while busy.
module inv_result_streamer #(
    parameter int wordLength = matrix_pkg::wordLength,
    parameter int NELEM      = matrix_pkg::NELEM
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  donem3,
    input  logic                  Error,
    input  logic [wordLength-1:0] out_inv11,
    input  logic [wordLength-1:0] out_inv12,
    input  logic [wordLength-1:0] out_inv13,
    input  logic [wordLength-1:0] out_inv21,
    input  logic [wordLength-1:0] out_inv22,
    input  logic [wordLength-1:0] out_inv23,
    input  logic [wordLength-1:0] out_inv31,
    input  logic [wordLength-1:0] out_inv32,
    input  logic [wordLength-1:0] out_inv33,
    output logic [wordLength-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_index,
    output logic                  out_last,
    output logic                  out_error,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [3:0] LAST_IDX = 4'(NELEM - 1);

    logic [0:0]            r_state;
    logic [3:0]            r_idx;
    logic                  r_error;
    logic                  r_overrun;
    logic [wordLength-1:0] r_bank [NELEM];

    logic [wordLength-1:0] w_in [NELEM];
    logic                  w_pulse;
    logic                  w_streaming;
    logic                  w_xfer;
    logic                  w_last_xfer;
    logic                  w_capture;
    logic                  w_drop;

    assign w_in[0] = out_inv11;
    assign w_in[1] = out_inv12;
    assign w_in[2] = out_inv13;
    assign w_in[3] = out_inv21;
    assign w_in[4] = out_inv22;
    assign w_in[5] = out_inv23;
    assign w_in[6] = out_inv31;
    assign w_in[7] = out_inv32;
    assign w_in[8] = out_inv33;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .d     (donem3),
        .pulse (w_pulse)
    );

    assign w_streaming = (r_state == matrix_pkg::ST_STREAM);
    assign w_xfer      = w_streaming & out_ready;
    assign w_last_xfer = w_xfer & (r_idx == LAST_IDX);

    // A result landing on the final transfer is taken back-to-back; anywhere
    // else in a frame it would corrupt the bank, so it is dropped and flagged.
    assign w_capture = w_pulse & (~w_streaming | w_last_xfer);
    assign w_drop    = w_pulse & w_streaming & ~w_last_xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= matrix_pkg::ST_IDLE;
            r_idx     <= 4'd0;
            r_error   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_capture) begin
                r_state <= matrix_pkg::ST_STREAM;
                r_idx   <= 4'd0;
                r_error <= Error;
            end else if (w_last_xfer) begin
                r_state <= matrix_pkg::ST_IDLE;
                r_idx   <= 4'd0;
            end else if (w_xfer) begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NELEM; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < NELEM; i++) begin
                r_bank[i] <= w_in[i];
            end
        end
    end

    assign out_data  = r_bank[r_idx];
    assign out_valid = w_streaming;
    assign out_index = r_idx;
    assign out_last  = w_streaming & (r_idx == LAST_IDX);
    assign out_error = r_error;
    assign busy      = w_streaming;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_inv_result_streamer.sv
// Directed bench for inv_result_streamer: streaming, stalls, overrun,
// back-to-back capture, error propagation and asynchronous reset.
module tb_inv_result_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        donem3 = 1'b0;
    logic        err_in = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] mat_in [9];
    logic [15:0] out_data;
    logic        out_valid;
    logic [3:0]  out_index;
    logic        out_last;
    logic        out_error;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inv_result_streamer #(.wordLength(16), .NELEM(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .donem3    (donem3),
        .Error     (err_in),
        .out_inv11 (mat_in[0]),
        .out_inv12 (mat_in[1]),
        .out_inv13 (mat_in[2]),
        .out_inv21 (mat_in[3]),
        .out_inv22 (mat_in[4]),
        .out_inv23 (mat_in[5]),
        .out_inv31 (mat_in[6]),
        .out_inv32 (mat_in[7]),
        .out_inv33 (mat_in[8]),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .out_error (out_error),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Test matrices: 0 identity, 1 negative Q4.12 values, 2 ramp, 3 "new" result, 4 misc
    function automatic logic [15:0] mat_elem(input int sel, input int k);
        case (sel)
            0:       return (k == 0 || k == 4 || k == 8) ? 16'h1000 : 16'h0000;
            1:       return 16'(32'hF000 + k * 32'h0111);
            2:       return 16'(32'h1111 * (k + 1));
            3:       return (k == 0) ? 16'h2000 : 16'h0AAA;
            default: return 16'(32'h0F00 - k * 3);
        endcase
    endfunction

    task automatic load_mat(input int sel);
        for (int k = 0; k < 9; k++) mat_in[k] = mat_elem(sel, k);
    endtask

    task automatic start_frame(input int sel, input logic err);
        load_mat(sel);
        err_in = err;
        @(negedge clk);
        donem3 = 1'b1;
        @(negedge clk);
        donem3 = 1'b0;
        err_in = 1'b0;
    endtask

    task automatic test_reset();
        load_mat(2);
        #1;
        checks++;
        if ({out_valid, busy, overrun, out_index, out_last, out_error, out_data} !== 24'h0) begin
            failures++;
            $display("FAIL reset_state got v=%b b=%b o=%b idx=%0d l=%b e=%b d=%h want all zero",
                     out_valid, busy, overrun, out_index, out_last, out_error, out_data);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, busy, out_data} !== 18'h0) begin
            failures++;
            $display("FAIL idle_after_release got v=%b b=%b d=%h want 0 0 0000", out_valid, busy, out_data);
        end
        $display("test_reset done");
    endtask

    task automatic test_identity();
        logic [22:0] got_v, exp_v;
        out_ready = 1'b1;
        start_frame(0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            got_v = {out_valid, out_index, out_last, out_error, out_data};
            exp_v = {1'b1, 4'(k), (k == 8), 1'b0, mat_elem(0, k)};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL identity_beat%0d got %h want %h", k, got_v, exp_v);
            end
            @(negedge clk);
        end
        checks++;
        if ({busy, out_valid, out_index} !== 6'h0) begin
            failures++;
            $display("FAIL identity_end got busy=%b valid=%b idx=%0d want 0 0 0", busy, out_valid, out_index);
        end
        $display("test_identity done");
    endtask

    task automatic test_backpressure();
        logic [22:0] got_v, exp_v;
        int got = 0;
        start_frame(1, 1'b0);
        for (int c = 0; c < 60 && got < 9; c++) begin
            out_ready = (c % 3 == 0);
            got_v = {out_valid, out_index, out_last, out_error, out_data};
            exp_v = {1'b1, 4'(got), (got == 8), 1'b0, mat_elem(1, got)};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL stall_cycle%0d got %h want %h (ready=%b)", c, got_v, exp_v, out_ready);
            end
            if (out_ready) got++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (got != 9) begin
            failures++;
            $display("FAIL stall_timeout got %0d beats want 9", got);
        end
        checks++;
        if ({busy, out_valid} !== 2'b00) begin
            failures++;
            $display("FAIL stall_end got busy=%b valid=%b want 0 0", busy, out_valid);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_last_edge();
        logic [22:0] got_v, exp_v;
        out_ready = 1'b1;
        start_frame(2, 1'b0);
        for (int k = 0; k < 9; k++) begin
            got_v = {out_valid, out_index, out_last, out_error, out_data};
            exp_v = {1'b1, 4'(k), (k == 8), 1'b0, mat_elem(2, k)};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL lastedge_a_beat%0d got %h want %h", k, got_v, exp_v);
            end
            if (k == 8) begin
                load_mat(3);
                donem3 = 1'b1;
            end
            @(negedge clk);
        end
        donem3 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            got_v = {out_valid, out_index, out_last, out_error, out_data};
            exp_v = {1'b1, 4'(k), (k == 8), 1'b0, mat_elem(3, k)};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL lastedge_b_beat%0d got %h want %h", k, got_v, exp_v);
            end
            @(negedge clk);
        end
        checks++;
        if ({busy, overrun} !== 2'b00) begin
            failures++;
            $display("FAIL lastedge_end got busy=%b overrun=%b want 0 0", busy, overrun);
        end
        $display("test_last_edge done");
    endtask

    task automatic test_error();
        logic [22:0] got_v, exp_v;
        out_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            start_frame(4, (f == 0));
            for (int k = 0; k < 9; k++) begin
                got_v = {out_valid, out_index, out_last, out_error, out_data};
                exp_v = {1'b1, 4'(k), (k == 8), (f == 0), mat_elem(4, k)};
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL error_f%0d_beat%0d got %h want %h", f, k, got_v, exp_v);
                end
                @(negedge clk);
            end
        end
        $display("test_error done");
    endtask

    task automatic test_overrun();
        logic [22:0] got_v, exp_v;
        int extra = 0;
        out_ready = 1'b1;
        start_frame(2, 1'b0);
        for (int k = 0; k < 9; k++) begin
            got_v = {out_valid, out_index, out_last, out_error, out_data};
            exp_v = {1'b1, 4'(k), (k == 8), 1'b0, mat_elem(2, k)};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL overrun_beat%0d got %h want %h", k, got_v, exp_v);
            end
            if (k == 3) begin
                load_mat(3);
                donem3 = 1'b1;
            end
            if (k == 4) donem3 = 1'b0;
            @(negedge clk);
        end
        checks++;
        if ({busy, overrun} !== 2'b01) begin
            failures++;
            $display("FAIL overrun_flag got busy=%b overrun=%b want 0 1", busy, overrun);
        end
        for (int c = 0; c < 6; c++) begin
            if (out_valid || !overrun) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL overrun_sticky got %0d bad cycles want 0", extra);
        end
        $display("test_overrun done");
    endtask

    task automatic test_reset_midframe();
        logic [22:0] got_v, exp_v;
        int seen = 0;
        out_ready = 1'b1;
        start_frame(1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k < 4) @(negedge clk);
        end
        checks++;
        if (out_index !== 4'd4) begin
            failures++;
            $display("FAIL midframe_pos got idx=%0d want 4", out_index);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, overrun, out_index, out_last, out_error, out_data} !== 24'h0) begin
            failures++;
            $display("FAIL async_reset got v=%b b=%b o=%b idx=%0d l=%b e=%b d=%h want all zero",
                     out_valid, busy, overrun, out_index, out_last, out_error, out_data);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL no_beats_after_reset got %0d beats want 0", seen);
        end
        load_mat(2);
        donem3 = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            got_v = {out_valid, out_index, out_last, out_error, out_data};
            exp_v = {1'b1, 4'(k), (k == 8), 1'b0, mat_elem(2, k)};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL held_done_beat%0d got %h want %h", k, got_v, exp_v);
            end
            @(negedge clk);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        donem3 = 1'b0;
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL held_done_single got %0d extra beats want 0", seen);
        end
        $display("test_reset_midframe done");
    endtask

    initial begin
        load_mat(0);
        test_reset();
        test_identity();
        test_backpressure();
        test_last_edge();
        test_error();
        test_overrun();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_result_streamer.md
INV_RESULT_STREAMER -- requirements
Module: inv_result_streamer

Interface
REQ-001 Parameter: wordLength, default 16, element width in Q4.12 signed fixed point.
REQ-002 Parameter: NELEM, default 9, elements per 3x3 result.
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 donem3  input  1  level "inverse ready" from the cordic_top inversion pipeline.
REQ-006 Error  input  1  inversion error flag from the cordic_top inversion pipeline, valid while donem3 high.
REQ-007 out_inv11..out_inv33  input  wordLength each  the nine inverse elements, valid while donem3 high.
REQ-008 out_data  output  wordLength  streamed element.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  consumer accepts the beat.
REQ-011 out_index  output  4  element index 0..8, row-major (0=inv11, 8=inv33).
REQ-012 out_last  output  1  high on the index-8 beat.
REQ-013 out_error  output  1  captured Error, held for every beat of the frame.
REQ-014 busy  output  1  frame captured and not fully transferred.
REQ-015 overrun  output  1  sticky: a result arrived while busy and was dropped.

Function
REQ-016 The block SHALL detect a rising edge of donem3 (donem3 high, registered donem3_q low).
REQ-017 On an edge in IDLE, the block SHALL capture all nine elements and Error into a register bank in the same cycle.
REQ-018 FSM states: IDLE, STREAM; IDLE->STREAM on capture; STREAM->IDLE on the index-8 transfer without a simultaneous edge.
REQ-019 out_valid SHALL assert on the cycle after capture (latency 1); busy SHALL equal (state==STREAM).
REQ-020 A transfer SHALL occur when out_valid and out_ready are both high; out_index then SHALL increment by 1.
REQ-021 While out_valid is high and out_ready is low, out_data, out_index, out_last and out_error SHALL hold stable.
REQ-022 out_data SHALL equal bank[out_index]; it SHALL be bit-exact with no rounding or saturation.
REQ-023 out_valid SHALL NOT deassert in STREAM until the index-8 transfer.
REQ-024 Edge during STREAM, not coinciding with the index-8 transfer: the result SHALL be dropped, the bank SHALL be left unchanged, and overrun SHALL be set.
REQ-025 Edge coinciding with the index-8 transfer: the new result SHALL be captured, the block SHALL stay in STREAM with out_index=0 next cycle, and overrun SHALL be left unchanged.
REQ-026 donem3 held high SHALL produce exactly one capture.
REQ-027 overrun SHALL clear only on reset.
REQ-028 In IDLE, out_valid, out_last and out_index SHALL be 0; out_data SHALL show bank[0].

Reset
REQ-029 Assertion (reset=0) SHALL immediately force state=IDLE, index=0, donem3_q=0, overrun=0, out_error=0 and bank=0, asynchronously.
REQ-030 Reset mid-frame SHALL abort the frame with no further beats.
REQ-031 If donem3 is high at the first clock after reset release, that SHALL count as an edge.

Structure
REQ-032 A shared package matrix_pkg SHALL hold wordLength, NELEM and the IDLE/STREAM state encoding.
REQ-033 Edge detection SHALL be a sub-module rise_detect (clk, reset, d, pulse).
REQ-034 The bank SHALL be nine wordLength registers with no memory macro.

Verification
REQ-035 Identity inverse (diag 16'h1000, others 0), donem3 pulse, out_ready=1 -> 9 consecutive beats 1000,0,0,0,1000,0,0,0,1000; out_last only on beat 9; busy low after.
REQ-036 out_ready toggling 1,0,0,1,... -> identical data sequence; outputs stable during every stall; no beat lost or duplicated.
REQ-037 Second donem3 edge at beat 4 with inv11=16'h2000 -> original frame completes unchanged; overrun=1 and stays 1.
REQ-038 Edge exactly on the index-8 transfer cycle -> next cycle out_index=0 with new frame data; overrun=0.
REQ-039 Error=1 at capture -> out_error=1 on all 9 beats; next frame with Error=0 -> out_error=0.
REQ-040 reset=0 at beat 5 -> out_valid=0 at once; after release no beats until a new donem3 edge; donem3 held high through reset -> exactly one frame.
